// File: rtl/loop_buf_pkg.sv
// rtl/loop_buf_pkg.sv - shared types and constants for the loop buffer read scheduler
package loop_buf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        DRAIN   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef struct packed {
        logic vld;
        logic sop;
        logic eop;
    } vld_flags_t;

    localparam int BLK_CNT_W = 16;

    // free_size reads back as the full block count when nothing is committed.
    function automatic int free_max(input int free_width);
        return 1 << (free_width - 1);
    endfunction

endpackage

// File: rtl/lb_vld_pipe.sv
// rtl/lb_vld_pipe.sv - fixed-depth shift register aligning {vld, sop, eop} with RAM read data
module lb_vld_pipe
    import loop_buf_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  vld_flags_t flags_in,
    output vld_flags_t flags_out
);

    vld_flags_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= flags_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign flags_out = stage[DEPTH-1];

endmodule

// File: rtl/loop_buffer_rd_ctrl.sv
// rtl/loop_buffer_rd_ctrl.sv - block read scheduler issuing intra-block addresses and releasing blocks
module loop_buffer_rd_ctrl
    import loop_buf_pkg::*;
#(
    parameter int RDATA_WIDTH  = 64,
    parameter int RADDR_WIDTH  = 8,
    parameter int BLOCK_LEN    = 256,
    parameter int READ_LATENCY = 3,
    parameter int FREE_WIDTH   = 2,
    parameter int FREE_MAX     = free_max(FREE_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sched_en,
    input  logic [FREE_WIDTH-1:0]  free_size,
    input  logic                   dn_ready,
    output logic [RADDR_WIDTH-1:0] rd_addr,
    output logic                   rd_rdy,
    input  logic [RDATA_WIDTH-1:0] rd_data,
    output logic [RDATA_WIDTH-1:0] m_data,
    output logic                   m_vld,
    output logic                   m_sop,
    output logic                   m_eop,
    output logic                   busy,
    output logic [BLK_CNT_W-1:0]   blk_cnt
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [RADDR_WIDTH-1:0] LAST_ADDR  = RADDR_WIDTH'(BLOCK_LEN - 1);
    localparam logic [FREE_WIDTH-1:0]  FREE_EMPTY = FREE_WIDTH'(FREE_MAX);
    localparam logic [CNT_W-1:0]       DRAIN_INIT = CNT_W'(READ_LATENCY - 1);

    state_t                 state, state_nxt;
    logic [RADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [CNT_W-1:0]       drain_q, drain_nxt;
    logic [BLK_CNT_W-1:0]   cnt_q, cnt_nxt;
    logic                   start;
    vld_flags_t             flags_in, flags_out;

    assign start = sched_en && (free_size != FREE_EMPTY) && dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            drain_q <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            drain_q <= drain_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        drain_nxt = drain_q;
        cnt_nxt   = cnt_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                    addr_nxt  = '0;
                end
            end
            READ: begin
                if (addr_q == LAST_ADDR) begin
                    state_nxt = DRAIN;
                    drain_nxt = DRAIN_INIT;
                end else begin
                    addr_nxt = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                // Wait for the last word's data to leave the RAM before releasing.
                if (drain_q == '0) begin
                    state_nxt = RELEASE;
                end else begin
                    drain_nxt = drain_q - 1'b1;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
                addr_nxt  = '0;
                cnt_nxt   = cnt_q + 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                addr_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        flags_in     = '0;
        flags_in.vld = (state == READ);
        flags_in.sop = (state == READ) && (addr_q == '0);
        flags_in.eop = (state == READ) && (addr_q == LAST_ADDR);
    end

    lb_vld_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_vld_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flags_in  (flags_in),
        .flags_out (flags_out)
    );

    assign rd_addr = addr_q;
    assign rd_rdy  = (state == RELEASE);
    assign busy    = (state != IDLE);
    assign blk_cnt = cnt_q;
    assign m_data  = rd_data;
    assign m_vld   = flags_out.vld;
    assign m_sop   = flags_out.sop;
    assign m_eop   = flags_out.eop;

endmodule

// File: tb/tb_loop_buffer_rd_ctrl.sv
// tb/tb_loop_buffer_rd_ctrl.sv - directed self-checking bench for loop_buffer_rd_ctrl
module tb_loop_buffer_rd_ctrl;

    localparam int RDATA_WIDTH  = 64;
    localparam int RADDR_WIDTH  = 8;
    localparam int BLOCK_LEN    = 8;
    localparam int READ_LATENCY = 3;
    localparam int FREE_WIDTH   = 2;
    localparam logic [1:0] FREE_EMPTY = 2'd2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   sched_en;
    logic [FREE_WIDTH-1:0]  free_size;
    logic                   dn_ready;
    logic [RADDR_WIDTH-1:0] rd_addr;
    logic                   rd_rdy;
    logic [RDATA_WIDTH-1:0] rd_data;
    logic [RDATA_WIDTH-1:0] m_data;
    logic                   m_vld;
    logic                   m_sop;
    logic                   m_eop;
    logic                   busy;
    logic [15:0]            blk_cnt;

    int checks = 0;
    int errors = 0;

    // Buffer RAM stand-in: word at address a reads back as D5_0000_0000_0000_aa.
    logic [RADDR_WIDTH-1:0] ram_pipe [READ_LATENCY];

    always_ff @(posedge clk) begin
        ram_pipe[0] <= rd_addr;
        for (int i = 1; i < READ_LATENCY; i++) begin
            ram_pipe[i] <= ram_pipe[i-1];
        end
    end

    assign rd_data = {8'hD5, 48'h0, ram_pipe[READ_LATENCY-1]};

    always #5 clk = ~clk;

    loop_buffer_rd_ctrl #(
        .RDATA_WIDTH  (RDATA_WIDTH),
        .RADDR_WIDTH  (RADDR_WIDTH),
        .BLOCK_LEN    (BLOCK_LEN),
        .READ_LATENCY (READ_LATENCY),
        .FREE_WIDTH   (FREE_WIDTH),
        .FREE_MAX     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sched_en  (sched_en),
        .free_size (free_size),
        .dn_ready  (dn_ready),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .rd_data   (rd_data),
        .m_data    (m_data),
        .m_vld     (m_vld),
        .m_sop     (m_sop),
        .m_eop     (m_eop),
        .busy      (busy),
        .blk_cnt   (blk_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag, input int exp_cnt);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " rd_rdy"}, 64'(rd_rdy), 64'd0);
        check({tag, " m_vld"}, 64'(m_vld), 64'd0);
        check({tag, " rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, " blk_cnt"}, 64'(blk_cnt), 64'(exp_cnt));
    endtask

    // Called at the negedge of the cycle where the start condition holds (T0).
    // Cycle T0+n: rd_addr = n-1 for n=1..8, m_vld for n=4..11, rd_rdy at n=12.
    task automatic run_block(input string tag, input int base, input int drop_at, input bit rel);
        int exp_addr;
        for (int n = 1; n <= 13; n++) begin
            step();
            exp_addr = (n <= BLOCK_LEN) ? n - 1 : ((n == 13) ? 0 : BLOCK_LEN - 1);
            check($sformatf("%s addr n%0d", tag, n), 64'(rd_addr), 64'(exp_addr));
            check($sformatf("%s vld n%0d", tag, n), 64'(m_vld), 64'(n >= 4 && n <= 11));
            check($sformatf("%s sop n%0d", tag, n), 64'(m_sop), 64'(n == 4));
            check($sformatf("%s eop n%0d", tag, n), 64'(m_eop), 64'(n == 11));
            check($sformatf("%s rdy n%0d", tag, n), 64'(rd_rdy), 64'(n == 12));
            check($sformatf("%s busy n%0d", tag, n), 64'(busy), 64'(n <= 12));
            check($sformatf("%s cnt n%0d", tag, n), 64'(blk_cnt), 64'((n == 13) ? base + 1 : base));
            if (n >= 4 && n <= 11) begin
                check($sformatf("%s data n%0d", tag, n), m_data, {8'hD5, 48'h0, 8'(n - 4)});
            end
            if (n == 1 && rel) free_size = FREE_EMPTY;
            if (n == drop_at) sched_en = 1'b0;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sched_en  = 1'b0;
        free_size = FREE_EMPTY;
        dn_ready  = 1'b0;
        step();
        step();
        check_idle("reset", 0);
        check("reset sop", 64'(m_sop), 64'd0);
        check("reset eop", 64'(m_eop), 64'd0);
        rst_n = 1'b1;

        // Empty buffer: never starts.
        sched_en = 1'b1;
        dn_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_idle($sformatf("empty c%0d", i), 0);
        end

        // Single block: free_size 2 -> 1.
        free_size = 2'd1;
        run_block("single", 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle($sformatf("single post c%0d", i), 1);
        end

        // Credit withheld, then granted.
        dn_ready  = 1'b0;
        free_size = 2'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_idle($sformatf("nocredit c%0d", i), 1);
        end
        dn_ready = 1'b1;
        run_block("credit", 1, 0, 1'b1);

        // Two committed blocks: exactly one IDLE cycle between them.
        free_size = 2'd0;
        run_block("b2b0", 2, 0, 1'b0);
        run_block("b2b1", 3, 0, 1'b1);
        step();
        check_idle("b2b post", 4);

        // sched_en dropped mid-READ.
        free_size = 2'd0;
        run_block("drop", 4, 3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle($sformatf("drop post c%0d", i), 5);
        end
        free_size = FREE_EMPTY;
        sched_en  = 1'b1;

        // Reset during DRAIN.
        free_size = 2'd1;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (n == 1) free_size = FREE_EMPTY;
        end
        check("pre-rst vld", 64'(m_vld), 64'd1);
        check("pre-rst busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_idle("async rst", 0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_idle($sformatf("in rst c%0d", i), 0);
        end
        rst_n     = 1'b1;
        free_size = 2'd1;
        run_block("after rst", 0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
